// File: rtl/n_bit_rcpa_pkg.sv
// -----------------------------------------------------------------------------
// n_bit_rcpa_pkg
// Shared constants and helpers for the approximate ripple-carry adder.
//   MODE_EXACT  (0) : exact full adder cell
//   MODE_NOTMAJ (1) : cout = majority(a,b,cin), s = ~cout
//   MODE_PASS   (2) : cout = a, s = b (cin ignored)
//   MODE_OR     (3) : cout = a & b, s = a | b | cin
// Optional feature macro used by the top: RCPA_ERRDIST_EN.
// -----------------------------------------------------------------------------
package n_bit_rcpa_pkg;

  localparam int MODE_EXACT  = 0;
  localparam int MODE_NOTMAJ = 1;
  localparam int MODE_PASS   = 2;
  localparam int MODE_OR     = 3;

  // Majority of three bits; the carry function of an exact full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    maj3 = (x & y) | (x & z) | (y & z);
  endfunction

  // Sum bit of an exact full adder.
  function automatic logic xor3(input logic x, input logic y, input logic z);
    xor3 = x ^ y ^ z;
  endfunction

endpackage

// File: rtl/n_bit_rcpa_cell.sv
// -----------------------------------------------------------------------------
// rcpa_cell
// One bit slice of the ripple chain. MODE selects the cell type (see
// n_bit_rcpa_pkg); any value outside 1..3 builds an exact full adder.
// Ports:
//   a, b  : operand bits
//   cin   : carry from the previous slice
//   s     : sum bit
//   cout  : carry to the next slice
// -----------------------------------------------------------------------------
module rcpa_cell
  import n_bit_rcpa_pkg::*;
#(
  parameter int MODE = MODE_EXACT
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Cell function chosen at elaboration by MODE.
  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    case (MODE)
      MODE_NOTMAJ: begin
        cout = maj3(a, b, cin);
        s    = ~cout;
      end
      MODE_PASS: begin
        // Carry-in deliberately ignored: this breaks the ripple path.
        cout = a;
        s    = b;
      end
      MODE_OR: begin
        cout = a & b;
        s    = a | b | cin;
      end
      default: begin
        cout = maj3(a, b, cin);
        s    = xor3(a, b, cin);
      end
    endcase
  end

endmodule

// File: rtl/n_bit_rcpa.sv
// -----------------------------------------------------------------------------
// n_bit_rcpa
// Approximate N-bit ripple-carry adder with a registered result.
// The K least-significant cells use the approximate cell selected by MODE;
// cells K..N-1 are exact. The combinational sum/carry are captured on every
// rising clk edge where in_valid=1 and held otherwise (1-cycle latency).
//
// Parameters:
//   N    : operand/sum width (2..64)
//   K    : number of approximate LSB cells (0..N)
//   MODE : approximate cell type (0 exact, 1 not-majority, 2 pass, 3 or)
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : A/B qualified this cycle
//   A, B      : unsigned operands
//   out_valid : sum/fn hold a new result
//   sum       : approximate sum bits N-1:0
//   fn        : carry out of cell N-1
// Optional (macro RCPA_ERRDIST_EN defined):
//   exact_sum : exact A+B including carry, registered alongside sum
//   err       : {fn,sum} != exact_sum
// -----------------------------------------------------------------------------
module n_bit_rcpa
  import n_bit_rcpa_pkg::*;
#(
  parameter int N    = 8,
  parameter int K    = N / 2,
  parameter int MODE = MODE_NOTMAJ
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         fn
`ifdef RCPA_ERRDIST_EN
  ,
  output logic [N:0]   exact_sum,
  output logic         err
`endif
);

  logic [N:0]   carry_s;
  logic [N-1:0] sum_s;

  logic [N-1:0] sum_d, sum_q;
  logic         fn_d, fn_q;
  logic         out_valid_d, out_valid_q;

  assign carry_s[0] = 1'b0;

  // Ripple chain: the low K cells take MODE, the rest are exact.
  for (genvar i = 0; i < N; i++) begin : g_cell
    localparam int CELL_MODE = (i < K) ? MODE : MODE_EXACT;
    rcpa_cell #(
      .MODE (CELL_MODE)
    ) u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry_s[i]),
      .s    (sum_s[i]),
      .cout (carry_s[i+1])
    );
  end

  // Next-state: load a new result on in_valid, otherwise hold.
  always_comb begin
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d = sum_s;
      fn_d  = carry_s[N];
    end else begin
      sum_d = sum_q;
      fn_d  = fn_q;
    end
  end

  // Result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= {N{1'b0}};
      fn_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      fn_q        <= fn_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign fn        = fn_q;
  assign out_valid = out_valid_q;

`ifdef RCPA_ERRDIST_EN
  logic [N:0] exact_s;
  logic [N:0] exact_sum_d, exact_sum_q;
  logic       err_d, err_q;

  assign exact_s = {1'b0, A} + {1'b0, B};

  // Error tracking loads with the same qualifier as the approximate result,
  // and err is formed from the values being loaded so the pair stays aligned.
  always_comb begin
    if (in_valid) begin
      exact_sum_d = exact_s;
      err_d       = ({carry_s[N], sum_s} != exact_s);
    end else begin
      exact_sum_d = exact_sum_q;
      err_d       = err_q;
    end
  end

  // Error-tracking registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_sum_q <= {(N+1){1'b0}};
      err_q       <= 1'b0;
    end else begin
      exact_sum_q <= exact_sum_d;
      err_q       <= err_d;
    end
  end

  assign exact_sum = exact_sum_q;
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_n_bit_rcpa.sv
module tb_n_bit_rcpa;

  localparam int NI = 6;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic [7:0] sum_o [NI];
  logic       fn_o  [NI];
  logic       ov_o  [NI];
`ifdef RCPA_ERRDIST_EN
  logic [8:0] exs_o [NI];
  logic       err_o [NI];
`endif

  // instance configs: 0..3 -> MODE 0..3 with K=4, 4 -> MODE1 K=0, 5 -> MODE1 K=8
  int dmode [NI];
  int dk    [NI];

  logic [7:0] exp_sum [NI];
  logic       exp_fn  [NI];
  logic       exp_ov;
  logic [8:0] exp_exs;
  logic       exp_err [NI];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RCPA_ERRDIST_EN
  `define ERRPORTS(I) , .exact_sum(exs_o[I]), .err(err_o[I])
`else
  `define ERRPORTS(I)
`endif

  n_bit_rcpa #(.N(8), .K(4), .MODE(0)) u_m0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a_in), .B(b_in), .out_valid(ov_o[0]), .sum(sum_o[0]), .fn(fn_o[0]) `ERRPORTS(0));
  n_bit_rcpa #(.N(8), .K(4), .MODE(1)) u_m1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a_in), .B(b_in), .out_valid(ov_o[1]), .sum(sum_o[1]), .fn(fn_o[1]) `ERRPORTS(1));
  n_bit_rcpa #(.N(8), .K(4), .MODE(2)) u_m2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a_in), .B(b_in), .out_valid(ov_o[2]), .sum(sum_o[2]), .fn(fn_o[2]) `ERRPORTS(2));
  n_bit_rcpa #(.N(8), .K(4), .MODE(3)) u_m3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a_in), .B(b_in), .out_valid(ov_o[3]), .sum(sum_o[3]), .fn(fn_o[3]) `ERRPORTS(3));
  n_bit_rcpa #(.N(8), .K(0), .MODE(1)) u_k0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a_in), .B(b_in), .out_valid(ov_o[4]), .sum(sum_o[4]), .fn(fn_o[4]) `ERRPORTS(4));
  n_bit_rcpa #(.N(8), .K(8), .MODE(1)) u_k8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a_in), .B(b_in), .out_valid(ov_o[5]), .sum(sum_o[5]), .fn(fn_o[5]) `ERRPORTS(5));

  // Reference: approximate low cells bit by bit from the cell rules, then the
  // exact upper part as plain integer addition of the shifted operands.
  function automatic logic [8:0] model(input int mode, input int k,
                                       input logic [7:0] a, input logic [7:0] b);
    int kk, c, lo, hi, ai, bi, s, nc;
    kk = (mode == 0) ? 0 : k;
    c  = 0;
    lo = 0;
    for (int i = 0; i < kk; i++) begin
      ai = a[i] ? 1 : 0;
      bi = b[i] ? 1 : 0;
      case (mode)
        1:       begin nc = (ai + bi + c >= 2) ? 1 : 0; s = 1 - nc; end
        2:       begin nc = ai; s = bi; end
        default: begin nc = ai & bi; s = ai | bi | c; end
      endcase
      lo = lo + (s << i);
      c  = nc;
    end
    hi = (int'(a) >> kk) + (int'(b) >> kk) + c;
    model = 9'((hi << kk) + lo);
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%0h want=%0h", name, d, act, exp);
    end
  endtask

  task automatic sb_clear();
    for (int d = 0; d < NI; d++) begin
      exp_sum[d] = 8'h00;
      exp_fn[d]  = 1'b0;
      exp_err[d] = 1'b0;
    end
    exp_ov  = 1'b0;
    exp_exs = 9'h000;
  endtask

  task automatic sb_capture(input logic v, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] m;
    exp_ov = v;
    if (v) begin
      exp_exs = 9'({1'b0, a} + {1'b0, b});
      for (int d = 0; d < NI; d++) begin
        m          = model(dmode[d], dk[d], a, b);
        exp_sum[d] = m[7:0];
        exp_fn[d]  = m[8];
        exp_err[d] = (m != exp_exs);
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < NI; d++) begin
      chk({tag, "_sum"}, d, 64'(sum_o[d]), 64'(exp_sum[d]));
      chk({tag, "_fn"},  d, 64'(fn_o[d]),  64'(exp_fn[d]));
      chk({tag, "_ov"},  d, 64'(ov_o[d]),  64'(exp_ov));
`ifdef RCPA_ERRDIST_EN
      chk({tag, "_exs"}, d, 64'(exs_o[d]), 64'(exp_exs));
      chk({tag, "_err"}, d, 64'(err_o[d]), 64'(exp_err[d]));
`endif
    end
  endtask

  // One clock: present inputs, capture at the edge, check #1 later.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input string tag);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
    sb_capture(v, a, b);
    check_all(tag);
  endtask

  typedef struct {
    int         d;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       f;
  } vec_t;

  vec_t tbl [8];

  initial begin
    dmode[0] = 0; dk[0] = 4;
    dmode[1] = 1; dk[1] = 4;
    dmode[2] = 2; dk[2] = 4;
    dmode[3] = 3; dk[3] = 4;
    dmode[4] = 1; dk[4] = 0;
    dmode[5] = 1; dk[5] = 8;

    tbl[0] = '{1, 8'h00, 8'h00, 8'h0F, 1'b0};
    tbl[1] = '{1, 8'hFF, 8'hFF, 8'hF0, 1'b1};
    tbl[2] = '{2, 8'h0F, 8'h01, 8'h11, 1'b0};
    tbl[3] = '{3, 8'h03, 8'h01, 8'h03, 1'b0};
    tbl[4] = '{0, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[5] = '{0, 8'h7F, 8'h7F, 8'hFE, 1'b0};
    tbl[6] = '{4, 8'hFF, 8'hFF, 8'hFE, 1'b1};
    tbl[7] = '{5, 8'h00, 8'h00, 8'hFF, 1'b0};

    // Reset state, including while clk runs with in_valid high.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a_in     = 8'h55;
    b_in     = 8'hAA;
    sb_clear();
    #3;
    check_all("rst_init");
    @(posedge clk);
    #1;
    check_all("rst_clk");

    // Operand presented in the cycle reset deasserts is captured next edge.
    a_in  = 8'h12;
    b_in  = 8'h34;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_capture(1'b1, 8'h12, 8'h34);
    check_all("rst_release");

    // Directed vectors with hand-computed results.
    for (int t = 0; t < 8; t++) begin
      step(1'b1, tbl[t].a, tbl[t].b, "tbl");
      chk("tbl_const_sum", tbl[t].d, 64'(sum_o[tbl[t].d]), 64'(tbl[t].s));
      chk("tbl_const_fn",  tbl[t].d, 64'(fn_o[tbl[t].d]),  64'(tbl[t].f));
`ifdef RCPA_ERRDIST_EN
      if (t == 1) begin
        chk("tbl_const_exs", 1, 64'(exs_o[1]), 64'h1FE);
        chk("tbl_const_err", 1, 64'(err_o[1]), 64'h1);
      end else if (t == 5) begin
        chk("tbl_const_err", 0, 64'(err_o[0]), 64'h0);
      end else begin
        chk("tbl_const_exs", 0, 64'(exs_o[0]), 64'(tbl[t].a + tbl[t].b));
      end
`endif
    end

    // Back-to-back valids, then idle: results held, out_valid low.
    step(1'b1, 8'h21, 8'h43, "b2b0");
    step(1'b1, 8'h9C, 8'h77, "b2b1");
    step(1'b1, 8'hE5, 8'h3B, "b2b2");
    step(1'b0, 8'h00, 8'hFF, "hold0");
    step(1'b0, 8'hFF, 8'hFF, "hold1");
    chk("hold_const_sum", 0, 64'(sum_o[0]), 64'h20);
    chk("hold_const_fn",  0, 64'(fn_o[0]),  64'h1);

    // Asynchronous reset between edges with a result held.
    step(1'b1, 8'hC8, 8'h5A, "pre_rst");
    in_valid = 1'b1;
    a_in     = 8'h0F;
    b_in     = 8'hF0;
    #3;
    rst_n = 1'b0;
    #1;
    sb_clear();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("async_rst_clk");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_capture(1'b1, 8'h0F, 8'hF0);
    check_all("post_rst");

    // Exhaustive sweep of the lower operand range for every configuration.
    for (int a = 0; a < 128; a++) begin
      for (int b = 0; b < 128; b++) begin
        step(1'b1, 8'(a), 8'(b), "sweep");
      end
    end

    // Random operands with random gaps in in_valid.
    for (int r = 0; r < 3000; r++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/n_bit_rcpa.md
N_BIT_RCPA -- requirements
Module: n_bit_rcpa

Interface
REQ-001 SHALL have parameter N, default 8: operand/sum width, legal range 2..64.
REQ-002 SHALL have parameter K, default N/2: count of approximate LSB cells, legal range 0..N.
REQ-003 SHALL have parameter MODE, default 1: approximate-cell type (0 exact, 1/2/3 per REQ-012..014).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  qualifies A/B this cycle.
REQ-007 SHALL have port A  input  N  operand A, unsigned.
REQ-008 SHALL have port B  input  N  operand B, unsigned.
REQ-009 SHALL have port out_valid  output  1  sum/fn hold a new result.
REQ-010 SHALL have port sum  output  N  approximate sum, bits N-1:0.
REQ-011 SHALL have port fn  output  1  final carry out of bit N-1.

Function
REQ-012 Cells 0..K-1 of the ripple chain are MODE cells; with MODE 1 each SHALL compute cout = majority(a,b,cin) and s = NOT cout.
REQ-013 With MODE 2, each approximate cell SHALL compute cout = a and s = b, with cin ignored.
REQ-014 With MODE 3, each approximate cell SHALL compute cout = a AND b and s = a OR b OR cin.
REQ-015 Cells K..N-1, and all cells when MODE=0, SHALL be exact full adders.
REQ-016 Carry into cell 0 SHALL be 0.
REQ-017 Each cell's cout SHALL feed cell i+1's cin.
REQ-018 The cout of cell N-1 SHALL drive fn.
REQ-019 The adder SHALL be purely combinational from A/B.
REQ-020 The result SHALL be registered: sum/fn load on the clk edge where in_valid=1, giving 1-cycle latency.
REQ-021 out_valid SHALL be the in_valid value registered on the same edge as REQ-020.
REQ-022 When in_valid=0, sum/fn SHALL hold their previous value.
REQ-023 There is no backpressure: a new operand pair SHALL be accepted on every cycle with in_valid=1.
REQ-024 All arithmetic SHALL be unsigned modulo 2^N, with overflow reported only on fn.
REQ-025 With K=0 the block SHALL behave as an exact adder; with K=N there are no exact cells.

Reset
REQ-026 While rst_n=0, sum, fn and out_valid SHALL be 0, asynchronously and regardless of clk.
REQ-027 An operand presented in the cycle rst_n deasserts SHALL be captured on the first following rising edge.
REQ-028 Reset mid-stream SHALL discard any in-flight result.

Configuration
REQ-029 When macro RCPA_ERRDIST_EN is defined, the block SHALL add output exact_sum (N+1 bits, registered alongside sum) holding A+B including carry.
REQ-030 When RCPA_ERRDIST_EN is defined, the block SHALL add output err (1 bit) = ({fn,sum} != exact_sum); both outputs SHALL reset to 0.
REQ-031 When RCPA_ERRDIST_EN is undefined, exact_sum and err and their logic SHALL be absent.

Structure
REQ-032 Package n_bit_rcpa_pkg SHALL hold the mode constants: MODE_EXACT=0, MODE_NOTMAJ=1, MODE_PASS=2, MODE_OR=3.
REQ-033 A sub-module rcpa_cell (inputs a, b, cin, parameter MODE; outputs s, cout) SHALL implement REQ-012..015, instantiated N times in a generate loop.

Verification (N=8, K=4)
REQ-034 MODE=1, A=0x00, B=0x00 -> sum=0x0F, fn=0, out_valid=1 one cycle after in_valid.
REQ-035 MODE=1, A=0xFF, B=0xFF -> sum=0xF0, fn=1; with RCPA_ERRDIST_EN: exact_sum=0x1FE, err=1.
REQ-036 MODE=2, A=0x0F, B=0x01 -> sum=0x11, fn=0; MODE=3, A=0x03, B=0x01 -> sum=0x03, fn=0.
REQ-037 MODE=0, A=0xFF, B=0x01 -> sum=0x00, fn=1; A=0x7F, B=0x7F -> sum=0xFE, fn=0, err=0.
REQ-038 Back-to-back in_valid for 3 cycles, then in_valid=0 -> three consecutive results, then sum held and out_valid=0.
REQ-039 Assert rst_n=0 between clock edges with a result held -> sum, fn, out_valid clear immediately.
REQ-040 Exhaustive sweep A,B in 0..127, all MODEs -> results match a bit-level model of REQ-012..017.
